// File: rtl/tcm_pkg.sv
// Shared TCM definitions: port-1 arbitration priority state, RAM row width
// and the helpers that place a 32-bit word into one half of a 64-bit row.
package tcm_pkg;

  typedef enum logic {
    CPU_PRI = 1'b0,
    EXT_PRI = 1'b1
  } pri_e;

  localparam int TCM_ROW_W = 13;
  localparam int ROW_LSB   = 3;
  localparam int ROW_MSB   = ROW_LSB + TCM_ROW_W - 1;
  localparam int LANE_BIT  = 2;

  // Lane 1 occupies the upper word of the row; the other half stays zero.
  function automatic logic [63:0] place_data(input logic lane, input logic [31:0] word);
    return lane ? {word, 32'h0} : {32'h0, word};
  endfunction

  function automatic logic [7:0] place_wr(input logic lane, input logic [3:0] be);
    return lane ? {be, 4'h0} : {4'h0, be};
  endfunction

endpackage

// File: rtl/tcm_port_arb.sv
// Port-1 arbiter for the TCM RAM: CPU has priority, but an external request
// refused MAX_WAIT times in a row is forced ahead of the CPU on the next cycle.
module tcm_port_arb
  import tcm_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int TAG_W    = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 cpu_rd_i,
  input  logic [3:0]           cpu_wr_i,
  input  logic                 cpu_nop_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic [TAG_W-1:0]     cpu_tag_i,
  output logic                 cpu_accept_o,
  output logic                 cpu_ack_o,
  output logic [TAG_W-1:0]     cpu_tag_o,
  output logic [31:0]          cpu_data_o,

  input  logic                 ext_rd_i,
  input  logic [3:0]           ext_wr_i,
  input  logic [31:0]          ext_addr_i,
  input  logic [31:0]          ext_data_i,
  output logic                 ext_accept_o,
  output logic                 ext_ack_o,
  output logic [31:0]          ext_data_o,

  output logic [TCM_ROW_W-1:0] ram_addr_o,
  output logic [7:0]           ram_wr_o,
  output logic [63:0]          ram_data_o,
  input  logic [63:0]          ram_data_i
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WAIT);

  pri_e                 pri_q, pri_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     wait_inc;
  logic                 cpu_req, ext_req;
  logic                 grant_cpu, grant_ext, any_grant;

  logic [31:0]          sel_addr;
  logic [31:0]          sel_data;
  logic [3:0]           sel_wr;
  logic                 sel_lane;

  logic [TCM_ROW_W-1:0] addr_q;
  logic                 cpu_ack_q, ext_ack_q;
  logic                 lane_q;
  logic [TAG_W-1:0]     tag_q;
  logic [31:0]          rd_word;

  logic                 unused_addr_bits;

  assign cpu_req  = cpu_rd_i | (|cpu_wr_i) | cpu_nop_i;
  assign ext_req  = ext_rd_i | (|ext_wr_i);
  assign wait_inc = wait_cnt_q + 1'b1;

  // Grants are purely combinational so the RAM sees the winner's address in
  // the same cycle; both are forced low while reset is held.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_ext  = 1'b0;
    pri_d      = pri_q;
    wait_cnt_d = wait_cnt_q;
    case (pri_q)
      CPU_PRI: begin
        if (cpu_req) begin
          grant_cpu = 1'b1;
        end else if (ext_req) begin
          grant_ext = 1'b1;
        end
        if (ext_req && !grant_ext) begin
          wait_cnt_d = wait_inc;
          if (wait_inc == MAX_CNT) begin
            pri_d = EXT_PRI;
          end
        end
        if (grant_ext) begin
          wait_cnt_d = '0;
        end
      end
      EXT_PRI: begin
        pri_d      = CPU_PRI;
        wait_cnt_d = '0;
        if (ext_req) begin
          grant_ext = 1'b1;
        end else begin
          grant_cpu = cpu_req;
        end
      end
      default: begin
        pri_d      = CPU_PRI;
        wait_cnt_d = '0;
      end
    endcase
    grant_cpu = grant_cpu & rst_ni;
    grant_ext = grant_ext & rst_ni;
  end

  assign any_grant    = grant_cpu | grant_ext;
  assign cpu_accept_o = grant_cpu;
  assign ext_accept_o = grant_ext;

  always_comb begin
    sel_addr = cpu_addr_i;
    sel_data = cpu_data_i;
    sel_wr   = cpu_nop_i ? 4'h0 : cpu_wr_i;
    if (grant_ext) begin
      sel_addr = ext_addr_i;
      sel_data = ext_data_i;
      sel_wr   = ext_wr_i;
    end
    sel_lane = sel_addr[LANE_BIT];
  end

  // Without a grant the row address parks on its last value.
  assign ram_addr_o = any_grant ? sel_addr[ROW_MSB:ROW_LSB] : addr_q;
  assign ram_wr_o   = any_grant ? place_wr(sel_lane, sel_wr) : 8'h0;
  assign ram_data_o = any_grant ? place_data(sel_lane, sel_data) : 64'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pri_q      <= CPU_PRI;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      cpu_ack_q  <= 1'b0;
      ext_ack_q  <= 1'b0;
      lane_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      pri_q      <= pri_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= ram_addr_o;
      cpu_ack_q  <= grant_cpu;
      ext_ack_q  <= grant_ext;
      if (any_grant) begin
        lane_q <= sel_lane;
      end
      if (grant_cpu) begin
        tag_q <= cpu_tag_i;
      end
    end
  end

  // One lane-muxed word feeds both requesters; each qualifies it by its own ack.
  assign rd_word    = lane_q ? ram_data_i[63:32] : ram_data_i[31:0];
  assign cpu_data_o = rd_word;
  assign ext_data_o = rd_word;
  assign cpu_ack_o  = cpu_ack_q;
  assign ext_ack_o  = ext_ack_q;
  assign cpu_tag_o  = tag_q;

  assign unused_addr_bits = ^{cpu_addr_i[31:ROW_MSB+1], cpu_addr_i[1:0],
                              ext_addr_i[31:ROW_MSB+1], ext_addr_i[1:0]};

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed self-checking bench for tcm_port_arb with default parameters
// (MAX_WAIT=4, TAG_W=11); each task drives one scenario and checks inline.
module tb_tcm_port_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cpu_rd_i, cpu_nop_i;
  logic [3:0]  cpu_wr_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic [10:0] cpu_tag_i;
  logic        cpu_accept_o, cpu_ack_o;
  logic [10:0] cpu_tag_o;
  logic [31:0] cpu_data_o;
  logic        ext_rd_i;
  logic [3:0]  ext_wr_i;
  logic [31:0] ext_addr_i, ext_data_i;
  logic        ext_accept_o, ext_ack_o;
  logic [31:0] ext_data_o;
  logic [12:0] ram_addr_o;
  logic [7:0]  ram_wr_o;
  logic [63:0] ram_data_o, ram_data_i;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk_i = ~clk_i;

  tcm_port_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_nop_i(cpu_nop_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_tag_i(cpu_tag_i),
    .cpu_accept_o(cpu_accept_o), .cpu_ack_o(cpu_ack_o), .cpu_tag_o(cpu_tag_o),
    .cpu_data_o(cpu_data_o),
    .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
    .ext_data_i(ext_data_i), .ext_accept_o(ext_accept_o), .ext_ack_o(ext_ack_o),
    .ext_data_o(ext_data_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    cpu_rd_i = 1'b0; cpu_wr_i = 4'h0; cpu_nop_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_data_i = 32'h0; cpu_tag_i = 11'h0;
    ext_rd_i = 1'b0; ext_wr_i = 4'h0; ext_addr_i = 32'h0; ext_data_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idleInputs();
    ram_data_i = 64'h1111_2222_3333_4444;
    ext_rd_i = 1'b1;
    ext_addr_i = 32'h0000_0104;
    tick();
    tick();
    testsRun++;
    if (ext_accept_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ext_accept got %b want 0", ext_accept_o); end
    testsRun++;
    if ({cpu_ack_o, ext_ack_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_acks got %b want 00", {cpu_ack_o, ext_ack_o}); end
    testsRun++;
    if (cpu_tag_o !== 11'h0) begin testsFailed++; $display("[TB] FAIL reset_tag got %h want 0", cpu_tag_o); end
    testsRun++;
    if ({ram_addr_o, ram_wr_o} !== 21'h0) begin testsFailed++; $display("[TB] FAIL reset_ram got addr %h wr %h want 0 0", ram_addr_o, ram_wr_o); end
    testsRun++;
    if (cpu_data_o !== 32'h3333_4444) begin testsFailed++; $display("[TB] FAIL reset_lane got %h want 33334444", cpu_data_o); end
  endtask

  task automatic test_ext_read();
    rst_ni = 1'b1;
    #1;
    testsRun++;
    if ({cpu_accept_o, ext_accept_o} !== 2'b01) begin testsFailed++; $display("[TB] FAIL extrd_accept got %b want 01", {cpu_accept_o, ext_accept_o}); end
    testsRun++;
    if (ram_addr_o !== 13'h20) begin testsFailed++; $display("[TB] FAIL extrd_addr got %h want 20", ram_addr_o); end
    testsRun++;
    if (ram_wr_o !== 8'h0) begin testsFailed++; $display("[TB] FAIL extrd_wr got %h want 0", ram_wr_o); end
    tick();
    ext_rd_i = 1'b0;
    #1;
    testsRun++;
    if ({cpu_ack_o, ext_ack_o} !== 2'b01) begin testsFailed++; $display("[TB] FAIL extrd_ack got %b want 01", {cpu_ack_o, ext_ack_o}); end
    testsRun++;
    if (ext_data_o !== 32'h1111_2222) begin testsFailed++; $display("[TB] FAIL extrd_data got %h want 11112222", ext_data_o); end
    tick();
    testsRun++;
    if (ext_ack_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL extrd_ack_once got %b want 0", ext_ack_o); end
    testsRun++;
    if (ram_addr_o !== 13'h20) begin testsFailed++; $display("[TB] FAIL extrd_addr_hold got %h want 20", ram_addr_o); end
  endtask

  task automatic test_back_to_back();
    cpu_wr_i = 4'hF; cpu_addr_i = 32'h10; cpu_data_i = 32'hDEAD_BEEF; cpu_tag_i = 11'h155;
    #1;
    testsRun++;
    if (cpu_accept_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_lo_accept got %b want 1", cpu_accept_o); end
    testsRun++;
    if (ram_wr_o !== 8'h0F) begin testsFailed++; $display("[TB] FAIL wr_lo_be got %h want 0f", ram_wr_o); end
    testsRun++;
    if (ram_data_o !== 64'h0000_0000_DEAD_BEEF) begin testsFailed++; $display("[TB] FAIL wr_lo_data got %h want 00000000deadbeef", ram_data_o); end
    testsRun++;
    if (ram_addr_o !== 13'h2) begin testsFailed++; $display("[TB] FAIL wr_lo_addr got %h want 2", ram_addr_o); end
    tick();
    cpu_wr_i = 4'h3; cpu_addr_i = 32'h1C; cpu_data_i = 32'hCAFE_F00D; cpu_tag_i = 11'h2AA;
    #1;
    testsRun++;
    if ({cpu_ack_o, cpu_tag_o} !== {1'b1, 11'h155}) begin testsFailed++; $display("[TB] FAIL wr_lo_ack got ack %b tag %h want 1 155", cpu_ack_o, cpu_tag_o); end
    testsRun++;
    if ({ram_wr_o, ram_addr_o} !== {8'h30, 13'h3}) begin testsFailed++; $display("[TB] FAIL wr_hi_ctl got wr %h addr %h want 30 3", ram_wr_o, ram_addr_o); end
    testsRun++;
    if (ram_data_o !== 64'hCAFE_F00D_0000_0000) begin testsFailed++; $display("[TB] FAIL wr_hi_data got %h want cafef00d00000000", ram_data_o); end
    tick();
    cpu_wr_i = 4'h0;
    ext_wr_i = 4'hC; ext_addr_i = 32'h204; ext_data_i = 32'h1234_5678;
    #1;
    testsRun++;
    if ({cpu_ack_o, cpu_tag_o} !== {1'b1, 11'h2AA}) begin testsFailed++; $display("[TB] FAIL wr_hi_ack got ack %b tag %h want 1 2aa", cpu_ack_o, cpu_tag_o); end
    testsRun++;
    if ({ext_accept_o, ram_wr_o, ram_addr_o} !== {1'b1, 8'hC0, 13'h40}) begin testsFailed++; $display("[TB] FAIL extwr_ctl got acc %b wr %h addr %h want 1 c0 40", ext_accept_o, ram_wr_o, ram_addr_o); end
    testsRun++;
    if (ram_data_o !== 64'h1234_5678_0000_0000) begin testsFailed++; $display("[TB] FAIL extwr_data got %h want 1234567800000000", ram_data_o); end
    tick();
    ext_wr_i = 4'h0;
    #1;
    testsRun++;
    if ({cpu_ack_o, ext_ack_o} !== 2'b01) begin testsFailed++; $display("[TB] FAIL extwr_ack got %b want 01", {cpu_ack_o, ext_ack_o}); end
    tick();
  endtask

  task automatic test_nop();
    ram_data_i = 64'hAAAA_0001_BBBB_0002;
    cpu_nop_i = 1'b1; cpu_addr_i = 32'h8; cpu_wr_i = 4'h0; cpu_tag_i = 11'h3A5;
    #1;
    testsRun++;
    if ({cpu_accept_o, ram_wr_o} !== {1'b1, 8'h00}) begin testsFailed++; $display("[TB] FAIL nop_ctl got acc %b wr %h want 1 00", cpu_accept_o, ram_wr_o); end
    tick();
    cpu_nop_i = 1'b0;
    #1;
    testsRun++;
    if ({cpu_ack_o, cpu_tag_o} !== {1'b1, 11'h3A5}) begin testsFailed++; $display("[TB] FAIL nop_ack got ack %b tag %h want 1 3a5", cpu_ack_o, cpu_tag_o); end
    testsRun++;
    if (cpu_data_o !== 32'hBBBB_0002) begin testsFailed++; $display("[TB] FAIL nop_data got %h want bbbb0002", cpu_data_o); end
    tick();
  endtask

  // Both sides request every cycle: the external side wins one cycle in five.
  task automatic test_fairness();
    logic expCpu, prevCpu;
    prevCpu = 1'b0;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h40;
    ext_rd_i = 1'b1; ext_addr_i = 32'h80;
    for (int i = 0; i < 15; i++) begin
      expCpu = ((i % 5) != 4);
      #1;
      testsRun++;
      if ({cpu_accept_o, ext_accept_o} !== {expCpu, !expCpu}) begin
        testsFailed++;
        $display("[TB] FAIL fair_grant cycle %0d got %b want %b", i, {cpu_accept_o, ext_accept_o}, {expCpu, !expCpu});
      end
      testsRun++;
      if (ram_addr_o !== (expCpu ? 13'h8 : 13'h10)) begin
        testsFailed++;
        $display("[TB] FAIL fair_addr cycle %0d got %h want %h", i, ram_addr_o, expCpu ? 13'h8 : 13'h10);
      end
      if (i > 0) begin
        testsRun++;
        if ({cpu_ack_o, ext_ack_o} !== {prevCpu, !prevCpu}) begin
          testsFailed++;
          $display("[TB] FAIL fair_ack cycle %0d got %b want %b", i, {cpu_ack_o, ext_ack_o}, {prevCpu, !prevCpu});
        end
      end
      prevCpu = expCpu;
      tick();
    end
    cpu_rd_i = 1'b0; ext_rd_i = 1'b0;
    #1;
    testsRun++;
    if ({cpu_ack_o, ext_ack_o} !== 2'b01) begin testsFailed++; $display("[TB] FAIL fair_last_ack got %b want 01", {cpu_ack_o, ext_ack_o}); end
    tick();
  endtask

  // Reach EXT_PRI, then withdraw ext; afterwards the full 4-cycle wait must restart.
  task automatic test_ext_withdraw();
    logic expCpu;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h40;
    ext_rd_i = 1'b1; ext_addr_i = 32'h80;
    for (int i = 0; i < 4; i++) tick();
    ext_rd_i = 1'b0;
    #1;
    testsRun++;
    if ({cpu_accept_o, ext_accept_o} !== 2'b10) begin testsFailed++; $display("[TB] FAIL withdraw_grant got %b want 10", {cpu_accept_o, ext_accept_o}); end
    tick();
    ext_rd_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expCpu = (i != 4);
      #1;
      testsRun++;
      if ({cpu_accept_o, ext_accept_o} !== {expCpu, !expCpu}) begin
        testsFailed++;
        $display("[TB] FAIL withdraw_restart cycle %0d got %b want %b", i, {cpu_accept_o, ext_accept_o}, {expCpu, !expCpu});
      end
      tick();
    end
    cpu_rd_i = 1'b0; ext_rd_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ram_data_i = 64'h5555_6666_7777_8888;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h1FC; cpu_tag_i = 11'h7FF;
    #1;
    testsRun++;
    if (cpu_accept_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_accept got %b want 1", cpu_accept_o); end
    tick();
    cpu_rd_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    testsRun++;
    if ({cpu_ack_o, ext_ack_o, cpu_tag_o} !== 13'h0) begin testsFailed++; $display("[TB] FAIL rstmid_ack got ack %b%b tag %h want 00 0", cpu_ack_o, ext_ack_o, cpu_tag_o); end
    testsRun++;
    if ({ram_addr_o, ram_wr_o} !== 21'h0) begin testsFailed++; $display("[TB] FAIL rstmid_ram got addr %h wr %h want 0 0", ram_addr_o, ram_wr_o); end
    testsRun++;
    if (cpu_data_o !== 32'h7777_8888) begin testsFailed++; $display("[TB] FAIL rstmid_lane got %h want 77778888", cpu_data_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    testsRun++;
    if ({cpu_ack_o, ext_ack_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL rstmid_replay got %b want 00", {cpu_ack_o, ext_ack_o}); end
  endtask

  initial begin
    test_reset();
    test_ext_read();
    test_back_to_back();
    test_nop();
    test_fairness();
    test_ext_withdraw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
